wave_bank_loader: RTL

- Sequences wavetable uploads from the wave SPI receiver into the four-bank wave RAM group of each voice.
- Generates write address, sub-bank one-hot, per-voice write enables and a write-clock strobe.
- After a complete 256-sample table is written, swaps each target voice's read bank to the new table at that voice's next phase wrap, so no table change occurs mid-cycle.
- Sits between the wave SPI receiver and the per-voice RAM arbiters, and replaces the fixed rbank wiring.

---
 rtl/wave_bank_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/wave_bank_loader.sv
// Wavetable upload sequencer: writes one 256-sample table into a wave RAM
// sub-bank, then swaps each target voice's read bank at its next phase wrap.
module wave_bank_loader #(
  parameter int DATAWIDTH    = 16,
  parameter int ADDRWIDTH    = 8,
  parameter int NVOICE       = 3,
  parameter int SWAP_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [NVOICE-1:0]     voice_mask,
  input  logic [1:0]            load_bank,
  input  logic                  s_valid,
  input  logic [DATAWIDTH-1:0]  s_data,
  input  logic [NVOICE-1:0]     wrap,
  output logic [DATAWIDTH-1:0]  wdata,
  output logic [ADDRWIDTH-1:0]  waddr,
  output logic [3:0]            wbank,
  output logic [NVOICE-1:0]     we_voice,
  output logic                  wclk,
  output logic [2*NVOICE-1:0]   rbank,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic                  conflict
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    SWAP
  } state_e;

  localparam logic [ADDRWIDTH-1:0] LAST = '1;
  localparam logic [15:0]          TMO  = 16'(SWAP_TIMEOUT);

  state_e                 state_q, state_d;
  logic                   load_en_q;
  logic [NVOICE-1:0]      vmask_q, vmask_d;
  logic [NVOICE-1:0]      pend_q, pend_d;
  logic [1:0]             bank_q, bank_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [ADDRWIDTH-1:0]   waddr_q, waddr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [2*NVOICE-1:0]    rbank_q, rbank_d;
  logic [15:0]            tmo_q, tmo_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;
  logic                   cfl_q, cfl_d;

  logic                   rise;
  logic                   clash;
  logic                   tmo_hit;
  logic                   wr_act;
  logic [NVOICE-1:0]      swap_now;

  assign rise     = load_en & ~load_en_q;
  assign tmo_hit  = (tmo_q == TMO);
  assign swap_now = pend_q & (wrap | {NVOICE{tmo_hit}});

  // A start clashes when the target bank is being read by any chosen voice
  always_comb begin
    clash = 1'b0;
    for (int v = 0; v < NVOICE; v++) begin
      if (voice_mask[v] && (rbank_q[2*v +: 2] == load_bank)) begin
        clash = 1'b1;
      end
    end
  end

  // Next-state logic for the upload / swap sequencer
  always_comb begin
    state_d = state_q;
    vmask_d = vmask_q;
    pend_d  = pend_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rbank_d = rbank_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    cfl_d   = cfl_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          vmask_d = voice_mask;
          bank_d  = load_bank;
          if (clash) begin
            cfl_d = 1'b1;
          end else if (voice_mask != '0) begin
            state_d = LOAD;
            addr_d  = '0;
          end
        end
      end
      LOAD: begin
        if (!load_en) begin
          state_d = IDLE;
        end else if (s_valid) begin
          wdata_d = s_data;
          waddr_d = addr_q;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (s_valid) begin
          ovr_d = 1'b1;
        end
        if (!load_en) begin
          state_d = IDLE;
        end else if (addr_q == LAST) begin
          state_d = SWAP;
          pend_d  = vmask_q;
          tmo_d   = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD;
        end
      end
      SWAP: begin
        for (int v = 0; v < NVOICE; v++) begin
          if (swap_now[v]) begin
            rbank_d[2*v +: 2] = bank_q;
          end
        end
        pend_d = pend_q & ~swap_now;
        if (tmo_q != 16'hFFFF) begin
          tmo_d = tmo_q + 16'd1;
        end
        if (pend_d == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      load_en_q <= 1'b0;
      vmask_q   <= '0;
      pend_q    <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rbank_q   <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cfl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_en_q <= load_en;
      vmask_q   <= vmask_d;
      pend_q    <= pend_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rbank_q   <= rbank_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      cfl_q     <= cfl_d;
    end
  end

  assign wr_act   = (state_q == LOAD) || (state_q == STROBE);
  assign wbank    = wr_act ? (4'b0001 << bank_q) : 4'b0000;
  assign we_voice = wr_act ? vmask_q : '0;
  assign wclk     = (state_q == STROBE) && load_en;
  assign wdata    = wdata_q;
  assign waddr    = waddr_q;
  assign rbank    = rbank_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overrun  = ovr_q;
  assign conflict = cfl_q;

endmodule
